// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - WB write, ID read and load-issue bundle for the register file
interface regfile_scoreboard_if;
   logic [4:0]  rf_waddr_WB_i;
   logic [31:0] rf_wdata_WB_i;
   logic        rf_we_WB_i;
   logic [4:0]  rf_raddr_a_i;
   logic [4:0]  rf_raddr_b_i;
   logic        rf_re_a_i;
   logic        rf_re_b_i;
   logic [31:0] rf_rdata_a_o;
   logic [31:0] rf_rdata_b_o;
   logic        ld_issue_i;
   logic [4:0]  ld_rd_i;
   logic        stall_o;
   logic [31:0] busy_o;

   modport master (
      output rf_waddr_WB_i, rf_wdata_WB_i, rf_we_WB_i,
      output rf_raddr_a_i, rf_raddr_b_i, rf_re_a_i, rf_re_b_i,
      output ld_issue_i, ld_rd_i,
      input  rf_rdata_a_o, rf_rdata_b_o, stall_o, busy_o
   );

   modport slave (
      input  rf_waddr_WB_i, rf_wdata_WB_i, rf_we_WB_i,
      input  rf_raddr_a_i, rf_raddr_b_i, rf_re_a_i, rf_re_b_i,
      input  ld_issue_i, ld_rd_i,
      output rf_rdata_a_o, rf_rdata_b_o, stall_o, busy_o
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 31x32 register file with WB bypass and load-use scoreboard
module regfile_scoreboard #(
   parameter bit BYPASS_EN  = 1'b1,
   parameter bit RESET_ZERO = 1'b1
) (
   input logic                  clk_i,
   input logic                  rst_ni,
   regfile_scoreboard_if.slave  rf
);

   logic [31:0] regs [1:31];
   logic [31:1] busy_q;
   logic [31:1] busy_d;
   logic [31:0] busy_full;
   logic        wr_en;
   logic        hit_a;
   logic        hit_b;
   logic [31:0] rdata_a;
   logic [31:0] rdata_b;

   assign wr_en = rf.rf_we_WB_i && (rf.rf_waddr_WB_i != 5'd0);
   assign hit_a = BYPASS_EN && rf.rf_we_WB_i && (rf.rf_waddr_WB_i == rf.rf_raddr_a_i);
   assign hit_b = BYPASS_EN && rf.rf_we_WB_i && (rf.rf_waddr_WB_i == rf.rf_raddr_b_i);

   // Storage either clears on reset or rides through it untouched.
   generate
      if (RESET_ZERO) begin : g_rst_zero
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               for (int i = 1; i < 32; i++) begin
                  regs[i] <= '0;
               end
            end else if (wr_en) begin
               regs[rf.rf_waddr_WB_i] <= rf.rf_wdata_WB_i;
            end
         end
      end else begin : g_rst_keep
         always_ff @(posedge clk_i) begin
            if (rst_ni && wr_en) begin
               regs[rf.rf_waddr_WB_i] <= rf.rf_wdata_WB_i;
            end
         end
      end
   endgenerate

   always_comb begin
      rdata_a = '0;
      rdata_b = '0;
      if (rf.rf_raddr_a_i != 5'd0) begin
         rdata_a = hit_a ? rf.rf_wdata_WB_i : regs[rf.rf_raddr_a_i];
      end
      if (rf.rf_raddr_b_i != 5'd0) begin
         rdata_b = hit_b ? rf.rf_wdata_WB_i : regs[rf.rf_raddr_b_i];
      end
   end

   assign rf.rf_rdata_a_o = rdata_a;
   assign rf.rf_rdata_b_o = rdata_b;

   // Set is applied after clear so a same-register collision leaves the bit busy.
   always_comb begin
      busy_d = busy_q;
      if (wr_en) begin
         busy_d[rf.rf_waddr_WB_i] = 1'b0;
      end
      if (rf.ld_issue_i && (rf.ld_rd_i != 5'd0)) begin
         busy_d[rf.ld_rd_i] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_full = {busy_q, 1'b0};
   assign rf.busy_o = busy_full;
   assign rf.stall_o = (rf.rf_re_a_i && busy_full[rf.rf_raddr_a_i] && !hit_a) ||
                       (rf.rf_re_b_i && busy_full[rf.rf_raddr_b_i] && !hit_b);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed bench for regfile_scoreboard, bypass and non-bypass builds
module tb_regfile_scoreboard;

   logic clk_i;
   logic rst_ni;
   int   checks;
   int   errors;

   regfile_scoreboard_if rf0 ();
   regfile_scoreboard_if rf1 ();

   regfile_scoreboard #(.BYPASS_EN(1'b1), .RESET_ZERO(1'b1)) dut0 (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .rf     (rf0)
   );

   regfile_scoreboard #(.BYPASS_EN(1'b0), .RESET_ZERO(1'b0)) dut1 (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .rf     (rf1)
   );

   assign rf1.rf_waddr_WB_i = rf0.rf_waddr_WB_i;
   assign rf1.rf_wdata_WB_i = rf0.rf_wdata_WB_i;
   assign rf1.rf_we_WB_i    = rf0.rf_we_WB_i;
   assign rf1.rf_raddr_a_i  = rf0.rf_raddr_a_i;
   assign rf1.rf_raddr_b_i  = rf0.rf_raddr_b_i;
   assign rf1.rf_re_a_i     = rf0.rf_re_a_i;
   assign rf1.rf_re_b_i     = rf0.rf_re_b_i;
   assign rf1.ld_issue_i    = rf0.ld_issue_i;
   assign rf1.ld_rd_i       = rf0.ld_rd_i;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      rf0.rf_we_WB_i    = 1'b0;
      rf0.rf_waddr_WB_i = '0;
      rf0.rf_wdata_WB_i = '0;
      rf0.ld_issue_i    = 1'b0;
      rf0.ld_rd_i       = '0;
      rf0.rf_re_a_i     = 1'b0;
      rf0.rf_re_b_i     = 1'b0;
   endtask

   task automatic wb(input logic [4:0] a, input logic [31:0] d);
      rf0.rf_we_WB_i    = 1'b1;
      rf0.rf_waddr_WB_i = a;
      rf0.rf_wdata_WB_i = d;
   endtask

   task automatic ld(input logic [4:0] rd);
      rf0.ld_issue_i = 1'b1;
      rf0.ld_rd_i    = rd;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      idle();
      rf0.rf_raddr_a_i = 5'd5;
      rf0.rf_raddr_b_i = 5'd0;
      rst_ni = 1'b1;
      #2 rst_ni = 1'b0;
      #1;
      chk("reset_busy", rf0.busy_o, 32'h0);
      chk("reset_stall", {31'b0, rf0.stall_o}, 32'h0);
      chk("reset_rdata_a", rf0.rf_rdata_a_o, 32'h0);
      repeat (2) tick();
      rst_ni = 1'b1;

      // Plain write then read next cycle
      wb(5'd5, 32'hDEADBEEF);
      tick();
      idle();
      #4;
      chk("read_x5", rf0.rf_rdata_a_o, 32'hDEADBEEF);
      chk("read_x0", rf0.rf_rdata_b_o, 32'h0);

      // Same-cycle bypass vs. stored value
      tick();
      wb(5'd7, 32'h11111111);
      tick();
      wb(5'd7, 32'h12345678);
      rf0.rf_raddr_a_i = 5'd7;
      #4;
      chk("bypass_on_x7", rf0.rf_rdata_a_o, 32'h12345678);
      chk("bypass_off_x7_old", rf1.rf_rdata_a_o, 32'h11111111);
      tick();
      idle();
      #4;
      chk("bypass_off_x7_new", rf1.rf_rdata_a_o, 32'h12345678);

      // Load-use stall and WB release
      tick();
      ld(5'd3);
      tick();
      idle();
      rf0.rf_raddr_a_i = 5'd3;
      rf0.rf_re_a_i    = 1'b1;
      #4;
      chk("ld3_stall", {31'b0, rf0.stall_o}, 32'h1);
      chk("ld3_busy", rf0.busy_o, 32'h00000008);
      tick();
      wb(5'd3, 32'h000000A5);
      #4;
      chk("wb3_stall_bypass", {31'b0, rf0.stall_o}, 32'h0);
      chk("wb3_rdata", rf0.rf_rdata_a_o, 32'h000000A5);
      chk("wb3_stall_nobypass", {31'b0, rf1.stall_o}, 32'h1);
      chk("wb3_busy_same", rf0.busy_o, 32'h00000008);
      tick();
      rf0.rf_we_WB_i = 1'b0;
      #4;
      chk("wb3_busy_clear", rf0.busy_o, 32'h0);
      chk("wb3_stall_after", {31'b0, rf0.stall_o}, 32'h0);

      // Set/clear collisions
      tick();
      idle();
      ld(5'd9);
      wb(5'd9, 32'h9);
      tick();
      idle();
      #4;
      chk("set_wins_x9", rf0.busy_o, 32'h00000200);
      tick();
      ld(5'd6);
      tick();
      idle();
      #4;
      chk("busy_6_9", rf0.busy_o, 32'h00000240);
      tick();
      ld(5'd4);
      wb(5'd6, 32'h66);
      tick();
      idle();
      #4;
      chk("set4_clear6", rf0.busy_o, 32'h00000210);

      // x0 write and rd=0 load are ignored
      tick();
      wb(5'd0, 32'hFFFFFFFF);
      ld(5'd0);
      rf0.rf_raddr_a_i = 5'd0;
      rf0.rf_re_a_i    = 1'b1;
      #4;
      chk("x0_bypass_zero", rf0.rf_rdata_a_o, 32'h0);
      chk("x0_stall", {31'b0, rf0.stall_o}, 32'h0);
      tick();
      idle();
      rf0.rf_re_a_i = 1'b1;
      #4;
      chk("x0_read", rf0.rf_rdata_a_o, 32'h0);
      chk("x0_busy", rf0.busy_o, 32'h00000210);

      // Asynchronous reset mid-operation
      tick();
      idle();
      wb(5'd10, 32'h0000CAFE);
      tick();
      idle();
      ld(5'd10);
      tick();
      ld(5'd11);
      tick();
      idle();
      rf0.rf_raddr_a_i = 5'd10;
      rf0.rf_raddr_b_i = 5'd11;
      rf0.rf_re_a_i    = 1'b1;
      #4;
      chk("busy_pre_reset", rf0.busy_o, 32'h00000E10);
      chk("stall_pre_reset", {31'b0, rf0.stall_o}, 32'h1);
      #2 rst_ni = 1'b0;
      #1;
      chk("async_busy", rf0.busy_o, 32'h0);
      chk("async_stall", {31'b0, rf0.stall_o}, 32'h0);
      chk("async_x10_zero", rf0.rf_rdata_a_o, 32'h0);
      chk("async_x10_kept", rf1.rf_rdata_a_o, 32'h0000CAFE);
      tick();
      tick();
      rst_ni = 1'b1;
      #4;
      chk("post_rst_x10_zero", rf0.rf_rdata_a_o, 32'h0);
      chk("post_rst_x10_kept", rf1.rf_rdata_a_o, 32'h0000CAFE);

      // Late WB for a load lost in reset updates data only
      tick();
      wb(5'd11, 32'h00000077);
      tick();
      idle();
      #4;
      chk("late_wb_busy", rf0.busy_o, 32'h0);
      chk("late_wb_data", rf0.rf_rdata_b_o, 32'h00000077);

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter BYPASS_EN, default 1, which enables WB-to-read forwarding in the same cycle.
REQ-002 SHALL have parameter RESET_ZERO, default 1, which clears x1..x31 on reset; when 0, x1..x31 keep their contents through reset.
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk_i input 1, rising-edge clock.
REQ-004 rst_ni  input  1  asynchronous reset, active low.
REQ-005 rf_waddr_WB_i  input  5  write address from the WB stage.
REQ-006 rf_wdata_WB_i  input  32  write data from the WB stage.
REQ-007 rf_we_WB_i  input  1  write enable from the WB stage.
REQ-008 rf_raddr_a_i, rf_raddr_b_i  input  5 each  read addresses from ID.
REQ-009 rf_re_a_i, rf_re_b_i  input  1 each  read-port-in-use qualifiers, used only for hazard detection.
REQ-010 rf_rdata_a_o, rf_rdata_b_o  output  32 each  read data.
REQ-011 ld_issue_i  input  1  a load is issued to the LSU this cycle.
REQ-012 ld_rd_i  input  5  destination register of the issued load.
REQ-013 stall_o  output  1  an ID read depends on an outstanding load.
REQ-014 busy_o  output  32  scoreboard vector; bit 0 is always 0.

Function
REQ-015 SHALL hold 31 x 32-bit registers x1..x31; x0 SHALL read 0, and writes to x0 SHALL be discarded.
REQ-016 SHALL write rf_wdata_WB_i into rf_waddr_WB_i on the rising clk_i edge when rf_we_WB_i=1 and the address is nonzero.
REQ-017 Read ports SHALL be combinational from the addresses, with zero cycles of latency.
REQ-018 With BYPASS_EN=1, a read port SHALL return rf_wdata_WB_i in the same cycle when rf_we_WB_i=1, the read address equals rf_waddr_WB_i, and the address is nonzero.
REQ-019 With BYPASS_EN=0, a read port SHALL return the stored value, and the new value SHALL be visible from the following cycle.
REQ-020 Scoreboard set: ld_issue_i=1 with ld_rd_i!=0 SHALL set busy[ld_rd_i] at the next edge.
REQ-021 Scoreboard clear: rf_we_WB_i=1 with a nonzero address SHALL clear busy[rf_waddr_WB_i] at the next edge.
REQ-022 When a set and a clear hit the same register in the same cycle, the set SHALL win and the bit SHALL end at 1.
REQ-023 When a set and a clear hit different registers in the same cycle, both SHALL take effect.
REQ-024 ld_issue_i with ld_rd_i=0 SHALL have no effect.
REQ-025 stall_o SHALL equal (rf_re_a_i & busy[raddr_a] & !hitA) | (rf_re_b_i & busy[raddr_b] & !hitB).
REQ-026 hitX in REQ-025 SHALL be 1 when BYPASS_EN=1, rf_we_WB_i=1 and rf_waddr_WB_i equals that read address; otherwise hitX=0.
REQ-027 stall_o SHALL be 0 for address 0 regardless of other inputs.
REQ-028 A WB write to a non-busy register SHALL update the data and leave the scoreboard unchanged.
REQ-029 ld_issue_i SHALL be accepted while stall_o=1; the issuing stage alone is responsible for gating it.
REQ-030 busy_o SHALL be the registered scoreboard, valid from the cycle after the set or clear edge.

Reset
REQ-031 While rst_ni=0, asynchronously and independent of clk_i: busy_o=0 and stall_o=0.
REQ-032 With RESET_ZERO=1, while rst_ni=0 all registers SHALL be 0 and rf_rdata_a_o = rf_rdata_b_o = 0, except bypassed data per REQ-018.
REQ-033 Reset asserted mid-operation SHALL discard all outstanding-load tracking; a WB write for that load arriving after reset SHALL update data only.
REQ-034 Writes SHALL resume on the first rising edge after rst_ni deasserts.

Verification
REQ-035 Write x5=0xDEADBEEF, then read a=5, b=0 next cycle -> rf_rdata_a_o=0xDEADBEEF, rf_rdata_b_o=0.
REQ-036 Same-cycle write x7=0x12345678 with raddr_a=7 -> rf_rdata_a_o=0x12345678 in that cycle (BYPASS_EN=1); with BYPASS_EN=0 -> old value in that cycle, new value next cycle.
REQ-037 Load issue rd=3; next cycle raddr_a=3, re_a=1 -> stall_o=1 and busy_o=0x00000008. Then WB writes x3=0xA5 -> stall_o=0 in that cycle, rf_rdata_a_o=0xA5, and busy_o=0 the following cycle.
REQ-038 Same cycle: ld_issue rd=9 and WB write x9 -> busy_o[9]=1 afterwards. Same cycle: ld_issue rd=4 and WB write x6 with busy[6]=1 -> busy_o has bit 4 set and bit 6 clear.
REQ-039 Write x0=0xFFFFFFFF and issue a load with rd=0 -> x0 reads 0, busy_o=0, stall_o=0.
REQ-040 Set busy[10] and busy[11], then assert rst_ni=0 between clock edges -> busy_o=0 and stall_o=0 immediately; with RESET_ZERO=1, x10 reads 0 after release.
